fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch stage sitting directly upstream of the asynchronous program ROM and downstream-feeding the execute stage.
- Owns the program counter and drives the ROM address bus; resolves JMP/CAL/RET locally using a hardware return-address stack.
- Hands every other instruction word to execute over a valid/ready handshake and accepts redirects (taken branches) from execute.

Parameters:
- ROM_WIDTH, 21, instruction word width; opcode = word[20:17], mode bit = word[16], operand = word[15:0].
- STACK_DEPTH, 8, number of return-address entries (power of two, 2..64).
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ADDR  output  16  ROM address, combinationally equal to pc.
- data  input  ROM_WIDTH  ROM word for ADDR (asynchronous ROM, valid same cycle).
- instr  output  ROM_WIDTH  registered instruction to execute.
- instr_pc  output  16  address instr was fetched from.
- instr_valid  output  1  instr holds a live instruction.
- instr_ready  input  1  execute accepts instr this cycle.
- br_taken  input  1  execute redirect, one-cycle pulse.
- br_target  input  16  redirect address.
- sp  output  $clog2(STACK_DEPTH)+1  current stack occupancy.
- fault  output  1  sticky; stack overflow/underflow (or PC wrap, see option).
- halted  output  1  high in HALT state.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, sp=0, instr=0, instr_pc=0, instr_valid=0, fault=0, halted=0, state=RUN. Stack contents undefined and never read while empty.
- Opcodes decoded from data: 4'b0100 JMP, 4'b0110 CAL, 4'b1000 RET; all others are "plain".
- Advance condition adv = state==RUN && (!instr_valid || instr_ready).
- Latency: ROM word is sampled in the same cycle pc is presented; plain instruction appears on instr one clock later.
- Priority per edge: rst > br_taken > fault > adv > hold.
- br_taken (any state except HALT): pc<=br_target, instr_valid<=0 (flush current fetch and any held instr); stack untouched.
- adv with plain word: instr<=data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (16-bit wrap FFFF->0000).
- adv with JMP: pc<=operand; instr_valid<=0 (JMP consumed, not forwarded).
- adv with CAL, sp<STACK_DEPTH: stack[sp]<=pc+1, sp<=sp+1, pc<=operand, instr_valid<=0.
- adv with CAL, sp==STACK_DEPTH: overflow: fault<=1, state<=HALT, pc unchanged.
- adv with RET, sp>0: pc<=stack[sp-1], sp<=sp-1, instr_valid<=0.
- adv with RET, sp==0: underflow: fault<=1, state<=HALT.
- Hold (instr_valid && !instr_ready): pc, instr, instr_pc, sp frozen; ADDR stable.
- HALT: instr_valid<=0 (after accepting nothing further), pc frozen, br_taken ignored; exit only via rst.
- Mode bit word[16] is ignored by this block and forwarded unchanged with plain words.

Optional Feature:
- FETCH_PC_WRAP_FAULT_EN defined: plain advance at pc==16'hFFFF sets fault, enters HALT, instr not loaded.
- Undefined: pc wraps silently to 16'h0000, no fault.

Test Plan:
- Reset with ROM {0:CAL 2, 1:JMP 0, 2..4:plain, 5:RET}, instr_ready=1 -> ADDR sequence 0,2,3,4,5,1,0,2...; instr_pc sequence 2,3,4 per loop; sp 0->1->0; fault=0.
- Hold: instr_ready=0 for 3 cycles while instr_pc=3 -> ADDR=4, instr/instr_pc stable, release resumes with instr_pc=4 next.
- Overflow: ROM word 0 = CAL 0, STACK_DEPTH=8 -> sp climbs to 8, ninth CAL sets fault=1, halted=1, instr_valid=0, ADDR frozen at 0.
- Underflow: ROM word 0 = RET -> first edge fault=1, halted=1, sp=0.
- Redirect collision: br_taken=1, br_target=16'h0040 in same cycle a CAL is fetched -> pc=0040, sp unchanged, instr_valid=0.
- Async reset mid-CAL (rst asserted between edges with sp=3) -> sp, pc, outputs return to reset values immediately; with FETCH_PC_WRAP_FAULT_EN, plain word at FFFF -> fault=1, otherwise ADDR=0000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, resolves JMP/CAL/RET with a return-address stack, and
// forwards all other words to execute. Define FETCH_PC_WRAP_FAULT_EN to fault on PC wrap.
module fetch_sequencer #(
    parameter int          ROM_WIDTH   = 21,
    parameter int          STACK_DEPTH = 8,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [15:0]                  ADDR,
    input  logic [ROM_WIDTH-1:0]         data,
    output logic [ROM_WIDTH-1:0]         instr,
    output logic [15:0]                  instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         br_taken,
    input  logic [15:0]                  br_target,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         fault,
    output logic                         halted
);

    localparam int              IDX_W   = $clog2(STACK_DEPTH);
    localparam int              SP_W    = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [3:0]      OP_JMP  = 4'b0100;
    localparam logic [3:0]      OP_CAL  = 4'b0110;
    localparam logic [3:0]      OP_RET  = 4'b1000;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t               state_r, state_s;
    logic [15:0]          pc_r, pc_s;
    logic [ROM_WIDTH-1:0] instr_r, instr_s;
    logic [15:0]          ipc_r, ipc_s;
    logic                 valid_r, valid_s;
    logic [SP_W-1:0]      sp_r, sp_s;
    logic                 fault_r, fault_s;
    logic                 push_s;
    logic                 adv_s;
    logic [3:0]           opcode_s;
    logic [15:0]          operand_s;
    logic [15:0]          pc_inc_s;
    logic [IDX_W-1:0]     top_idx_s;
    logic [15:0]          stack_r [STACK_DEPTH];

    assign opcode_s  = data[ROM_WIDTH-1 -: 4];
    assign operand_s = data[15:0];
    assign pc_inc_s  = pc_r + 16'd1;
    assign top_idx_s = IDX_W'(sp_r - SP_W'(1));
    assign adv_s     = (state_r == ST_RUN) && (!valid_r || instr_ready);

    // Next-state and datapath decode; a redirect outranks everything, HALT absorbs all else.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        ipc_s   = ipc_r;
        valid_s = valid_r;
        sp_s    = sp_r;
        fault_s = fault_r;
        push_s  = 1'b0;
        if (br_taken && (state_r == ST_RUN)) begin
            pc_s    = br_target;
            valid_s = 1'b0;
        end else if (state_r == ST_HALT) begin
            valid_s = 1'b0;
        end else if (adv_s) begin
            case (opcode_s)
                OP_JMP: begin
                    pc_s    = operand_s;
                    valid_s = 1'b0;
                end
                OP_CAL: begin
                    valid_s = 1'b0;
                    if (sp_r == SP_FULL) begin
                        fault_s = 1'b1;
                        state_s = ST_HALT;
                    end else begin
                        push_s = 1'b1;
                        sp_s   = sp_r + SP_W'(1);
                        pc_s   = operand_s;
                    end
                end
                OP_RET: begin
                    valid_s = 1'b0;
                    if (sp_r == {SP_W{1'b0}}) begin
                        fault_s = 1'b1;
                        state_s = ST_HALT;
                    end else begin
                        sp_s = sp_r - SP_W'(1);
                        pc_s = stack_r[top_idx_s];
                    end
                end
                default: begin
`ifdef FETCH_PC_WRAP_FAULT_EN
                    if (pc_r == 16'hFFFF) begin
                        fault_s = 1'b1;
                        state_s = ST_HALT;
                        valid_s = 1'b0;
                    end else begin
                        instr_s = data;
                        ipc_s   = pc_r;
                        valid_s = 1'b1;
                        pc_s    = pc_inc_s;
                    end
`else
                    instr_s = data;
                    ipc_s   = pc_r;
                    valid_s = 1'b1;
                    pc_s    = pc_inc_s;
`endif
                end
            endcase
        end else begin
            valid_s = valid_r;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
            instr_r <= {ROM_WIDTH{1'b0}};
            ipc_r   <= 16'h0000;
            valid_r <= 1'b0;
            sp_r    <= {SP_W{1'b0}};
            fault_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            instr_r <= instr_s;
            ipc_r   <= ipc_s;
            valid_r <= valid_s;
            sp_r    <= sp_s;
            fault_r <= fault_s;
        end
    end

    // Return-address storage; contents are only read while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_r[sp_r[IDX_W-1:0]] <= pc_inc_s;
        end
    end

    assign ADDR        = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = ipc_r;
    assign instr_valid = valid_r;
    assign sp          = sp_r;
    assign fault       = fault_r;
    assign halted      = (state_r == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer driving a small behavioural ROM.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ADDR;
    logic [20:0] data;
    logic [20:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [3:0]  sp;
    logic        fault;
    logic        halted;

    logic [20:0] rom [256];
    int n_cmp = 0;
    int n_err = 0;

    localparam logic [20:0] P2  = {4'b0001, 1'b1, 16'hA002};
    localparam logic [20:0] P3  = {4'b0010, 1'b0, 16'hB003};
    localparam logic [20:0] P4  = {4'b1111, 1'b1, 16'hC004};
    localparam logic [20:0] P40 = {4'b0011, 1'b0, 16'h0040};

    assign data = rom[ADDR[7:0]];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .ADDR(ADDR), .data(data), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .br_taken(br_taken), .br_target(br_target), .sp(sp), .fault(fault), .halted(halted)
    );

    function automatic logic [20:0] w(input logic [3:0] op, input logic [15:0] opd);
        return {op, 1'b0, opd};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 21'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; br_taken = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_loop();
        clear_rom();
        rom[0] = w(4'b0110, 16'h0002);
        rom[1] = w(4'b0100, 16'h0000);
        rom[2] = P2; rom[3] = P3; rom[4] = P4;
        rom[5] = w(4'b1000, 16'h0000);
    endtask

    task automatic test_reset();
        load_loop();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (ADDR !== 16'h0000) begin n_err++; $display("FAIL reset_addr got %h want 0000", ADDR); end
        n_cmp++; if (sp !== 4'd0) begin n_err++; $display("FAIL reset_sp got %0d want 0", sp); end
        n_cmp++; if (instr !== 21'd0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 16'h0000) begin n_err++; $display("FAIL reset_ipc got %h want 0", instr_pc); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        n_cmp++; if (fault !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL reset_flags got %b%b want 00", fault, halted); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loop();
        logic [15:0] ea [8]  = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd1, 16'd0, 16'd2, 16'd3};
        logic [3:0]  es [8]  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1};
        logic        ev [8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ep [8]  = '{16'd0, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd2};
        logic [20:0] ew [8]  = '{21'd0, P2, P3, P4, 21'd0, 21'd0, 21'd0, P2};
        load_loop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (ADDR !== ea[i]) begin n_err++; $display("FAIL loop_addr[%0d] got %h want %h", i, ADDR, ea[i]); end
            n_cmp++; if (sp !== es[i]) begin n_err++; $display("FAIL loop_sp[%0d] got %0d want %0d", i, sp, es[i]); end
            n_cmp++; if (instr_valid !== ev[i]) begin n_err++; $display("FAIL loop_valid[%0d] got %b want %b", i, instr_valid, ev[i]); end
            if (ev[i]) begin
                n_cmp++; if (instr_pc !== ep[i]) begin n_err++; $display("FAIL loop_ipc[%0d] got %h want %h", i, instr_pc, ep[i]); end
                n_cmp++; if (instr !== ew[i]) begin n_err++; $display("FAIL loop_instr[%0d] got %h want %h", i, instr, ew[i]); end
            end
        end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL loop_fault got %b want 0", fault); end
    endtask

    task automatic test_hold();
        load_loop();
        do_reset();
        repeat (3) step();
        n_cmp++; if (instr_pc !== 16'd3 || ADDR !== 16'd4) begin n_err++; $display("FAIL hold_pre got ipc %h addr %h want 3/4", instr_pc, ADDR); end
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (ADDR !== 16'd4) begin n_err++; $display("FAIL hold_addr[%0d] got %h want 0004", i, ADDR); end
            n_cmp++; if (instr_pc !== 16'd3 || instr !== P3 || instr_valid !== 1'b1) begin
                n_err++; $display("FAIL hold_instr[%0d] got %h@%h v%b want %h@0003 v1", i, instr, instr_pc, instr_valid, P3); end
        end
        instr_ready = 1'b1;
        step();
        n_cmp++; if (instr_pc !== 16'd4 || ADDR !== 16'd5) begin n_err++; $display("FAIL hold_release got ipc %h addr %h want 4/5", instr_pc, ADDR); end
    endtask

    task automatic test_overflow();
        clear_rom();
        rom[0] = w(4'b0110, 16'h0000);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++; if (sp !== 4'(i) || ADDR !== 16'h0000 || fault !== 1'b0) begin
                n_err++; $display("FAIL ovf_climb[%0d] got sp %0d addr %h f%b want sp %0d addr 0 f0", i, sp, ADDR, fault, i); end
        end
        step();
        n_cmp++; if (fault !== 1'b1 || halted !== 1'b1) begin n_err++; $display("FAIL ovf_flags got f%b h%b want 11", fault, halted); end
        n_cmp++; if (instr_valid !== 1'b0 || sp !== 4'd8 || ADDR !== 16'h0000) begin
            n_err++; $display("FAIL ovf_state got v%b sp %0d addr %h want v0 sp 8 addr 0", instr_valid, sp, ADDR); end
        br_taken = 1'b1; br_target = 16'h0040;
        step();
        br_taken = 1'b0;
        n_cmp++; if (ADDR !== 16'h0000 || halted !== 1'b1) begin n_err++; $display("FAIL halt_ignores_br got addr %h h%b want 0000 h1", ADDR, halted); end
    endtask

    task automatic test_underflow();
        clear_rom();
        rom[0] = w(4'b1000, 16'h0000);
        do_reset();
        step();
        n_cmp++; if (fault !== 1'b1 || halted !== 1'b1 || sp !== 4'd0) begin
            n_err++; $display("FAIL udf got f%b h%b sp %0d want 1 1 0", fault, halted, sp); end
    endtask

    task automatic test_redirect();
        load_loop();
        rom[8'h40] = P40;
        do_reset();
        br_taken = 1'b1; br_target = 16'h0040;
        step();
        br_taken = 1'b0;
        n_cmp++; if (ADDR !== 16'h0040 || sp !== 4'd0 || instr_valid !== 1'b0) begin
            n_err++; $display("FAIL redirect got addr %h sp %0d v%b want 0040 0 0", ADDR, sp, instr_valid); end
        step();
        n_cmp++; if (instr_pc !== 16'h0040 || instr !== P40 || ADDR !== 16'h0041) begin
            n_err++; $display("FAIL redirect_fetch got %h@%h addr %h want %h@0040 addr 0041", instr, instr_pc, ADDR, P40); end
    endtask

    task automatic test_async_reset();
        clear_rom();
        rom[0] = w(4'b0110, 16'h0001);
        rom[1] = w(4'b0110, 16'h0002);
        rom[2] = w(4'b0110, 16'h0003);
        rom[3] = w(4'b0110, 16'h0004);
        do_reset();
        repeat (3) step();
        n_cmp++; if (sp !== 4'd3 || ADDR !== 16'h0003) begin n_err++; $display("FAIL arst_pre got sp %0d addr %h want 3 0003", sp, ADDR); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sp !== 4'd0 || ADDR !== 16'h0000 || instr_valid !== 1'b0 || fault !== 1'b0) begin
            n_err++; $display("FAIL arst got sp %0d addr %h v%b f%b want 0 0000 0 0", sp, ADDR, instr_valid, fault); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0]     = w(4'b0100, 16'hFFFF);
        rom[8'hFF] = P2;
        do_reset();
        step();
        n_cmp++; if (ADDR !== 16'hFFFF || instr_valid !== 1'b0) begin n_err++; $display("FAIL wrap_jmp got addr %h v%b want FFFF 0", ADDR, instr_valid); end
        step();
`ifdef FETCH_PC_WRAP_FAULT_EN
        n_cmp++; if (fault !== 1'b1 || halted !== 1'b1 || instr_valid !== 1'b0) begin
            n_err++; $display("FAIL wrap_fault got f%b h%b v%b want 1 1 0", fault, halted, instr_valid); end
`else
        n_cmp++; if (ADDR !== 16'h0000 || instr_pc !== 16'hFFFF || instr_valid !== 1'b1 || fault !== 1'b0) begin
            n_err++; $display("FAIL wrap got addr %h ipc %h v%b f%b want 0000 FFFF 1 0", ADDR, instr_pc, instr_valid, fault); end
`endif
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_loop();
        test_hold();
        test_overflow();
        test_underflow();
        test_redirect();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
